// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC in-service controller.
// Holds the handshake state enum, reset pointer and priority-rank helper.
package pic_pkg;

   typedef enum logic {
      IDLE,
      WAIT_ACK2
   } pic_state_e;

   localparam int PIC_DEF_NUM_IRQ = 8;
   localparam int PIC_RST_LOWEST  = PIC_DEF_NUM_IRQ - 1;

   // Reset value of the lowest-priority pointer (IR0 highest).
   function automatic int pic_rst_lowest(int num_irq);
      return num_irq - 1;
   endfunction

   // Rank 0 is the highest priority; larger ranks are lower priority.
   function automatic int pic_rank(int idx, int low, int num_irq);
      return (idx - low - 1 + 2 * num_irq) % num_irq;
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: finds the highest-priority set bit of req.
// Ports: req, lowest_prio in; found, idx out.
module pic_priority_resolver
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req,
   input  logic [ID_W-1:0]    lowest_prio,
   output logic               found,
   output logic [ID_W-1:0]    idx
);

   // Walk from lowest to highest priority so the last hit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = NUM_IRQ; k >= 1; k--) begin
         int ch;
         ch = (int'(lowest_prio) + k) % NUM_IRQ;
         if (req[ch]) begin
            found = 1'b1;
            idx   = ID_W'(ch);
         end
      end
   end

endmodule

// File: rtl/pic_isr_ctrl.sv
// In-service controller: nested priority, INTA handshake, EOI, rotation.
// Ports: clk/reset, irq_pending, INTA/EOI/prio cmds; ISR, irr_clear, int, vector.
module pic_isr_ctrl
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_pending,
   input  logic               inta_first,
   input  logic               inta_second,
   input  logic               aeoi_mode,
   input  logic               rotate_on_eoi,
   input  logic               eoi_nonspecific,
   input  logic               eoi_specific,
   input  logic [ID_W-1:0]    eoi_level,
   input  logic               prio_set,
   output logic [NUM_IRQ-1:0] in_service,
   output logic [NUM_IRQ-1:0] irr_clear,
   output logic               int_out,
   output logic [ID_W-1:0]    vector_id,
   output logic               vector_valid
);

   localparam logic [ID_W-1:0] RST_LOW = ID_W'(pic_rst_lowest(NUM_IRQ));

   pic_state_e         state, state_n;
   logic [ID_W-1:0]    lowest_prio, lowest_n;
   logic [NUM_IRQ-1:0] isr_n, irr_clear_n, set_v, clr_v;
   logic [ID_W-1:0]    vector_id_n;
   logic               vector_valid_n, int_out_n;
   logic               spurious, spurious_n;

   logic               cand_found, top_found, eligible, eoi_ok;
   logic [ID_W-1:0]    cand_idx, top_idx;

   pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
      .req         (irq_pending),
      .lowest_prio (lowest_prio),
      .found       (cand_found),
      .idx         (cand_idx)
   );

   pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
      .req         (in_service),
      .lowest_prio (lowest_prio),
      .found       (top_found),
      .idx         (top_idx)
   );

   assign eoi_ok = int'(eoi_level) < NUM_IRQ;

   always_comb begin
      eligible = 1'b0;
      if (cand_found) begin
         if (!top_found)
            eligible = 1'b1;
         else
            eligible = pic_rank(int'(cand_idx), int'(lowest_prio), NUM_IRQ)
                     < pic_rank(int'(top_idx), int'(lowest_prio), NUM_IRQ);
      end
   end

   always_comb begin
      state_n        = state;
      lowest_n       = lowest_prio;
      set_v          = '0;
      clr_v          = '0;
      irr_clear_n    = '0;
      vector_id_n    = vector_id;
      vector_valid_n = 1'b0;
      spurious_n     = spurious;
      int_out_n      = (state == IDLE) && eligible;

      // Specific EOI dominates a simultaneous non-specific one.
      if (eoi_specific) begin
         if (eoi_ok) begin
            clr_v[eoi_level] = 1'b1;
            if (rotate_on_eoi)
               lowest_n = eoi_level;
         end
      end else if (eoi_nonspecific && top_found) begin
         clr_v[top_idx] = 1'b1;
         if (rotate_on_eoi)
            lowest_n = top_idx;
      end

      unique case (state)
         IDLE: begin
            if (inta_first) begin
               state_n = WAIT_ACK2;
               if (eligible) begin
                  set_v[cand_idx]       = 1'b1;
                  irr_clear_n[cand_idx] = 1'b1;
                  vector_id_n           = cand_idx;
                  spurious_n            = 1'b0;
               end else begin
                  vector_id_n = RST_LOW;
                  spurious_n  = 1'b1;
               end
            end
         end
         WAIT_ACK2: begin
            if (inta_second) begin
               state_n        = IDLE;
               vector_valid_n = 1'b1;
               if (aeoi_mode && !spurious) begin
                  clr_v[vector_id] = 1'b1;
                  if (rotate_on_eoi)
                     lowest_n = vector_id;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // An explicit pointer load overrides any rotation this cycle.
      if (prio_set && eoi_ok)
         lowest_n = eoi_level;

      isr_n = (in_service & ~clr_v) | set_v;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         lowest_prio  <= RST_LOW;
         in_service   <= '0;
         irr_clear    <= '0;
         int_out      <= 1'b0;
         vector_id    <= '0;
         vector_valid <= 1'b0;
         spurious     <= 1'b0;
      end else begin
         state        <= state_n;
         lowest_prio  <= lowest_n;
         in_service   <= isr_n;
         irr_clear    <= irr_clear_n;
         int_out      <= int_out_n;
         vector_id    <= vector_id_n;
         vector_valid <= vector_valid_n;
         spurious     <= spurious_n;
      end
   end

endmodule

// File: doc/pic_isr_ctrl.md
Name: pic_isr_ctrl

Overview:
Clocked, parametrised in-service controller for the PIC. It is the successor to the combinational in-service register. It resolves the highest-priority pending request against the current in-service set (fully nested mode) and runs the two-pulse INTA handshake. It sets and clears in-service bits, supports specific, non-specific and automatic EOI, and maintains a rotating priority pointer. It sits between the IRR/IMR stage, which supplies already-masked requests, and the control/data-bus logic, which supplies INTA and OCW commands and consumes the vector ID.

Parameters:
NUM_IRQ, 8, number of interrupt channels (2..32)
ID_W, $clog2(NUM_IRQ), width of a channel index

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
irq_pending  input  NUM_IRQ  masked pending requests from the IRR (level)
inta_first  input  1  one-cycle pulse, first INTA: resolve and accept a request
inta_second  input  1  one-cycle pulse, second INTA: deliver the vector
aeoi_mode  input  1  automatic EOI enable
rotate_on_eoi  input  1  rotate priority on every EOI (including AEOI)
eoi_nonspecific  input  1  pulse: clear the highest-priority in-service bit
eoi_specific  input  1  pulse: clear in-service bit eoi_level
eoi_level  input  ID_W  channel for a specific EOI
prio_set  input  1  pulse: load the lowest-priority pointer with eoi_level
in_service  output  NUM_IRQ  in-service register
irr_clear  output  NUM_IRQ  one-hot, one-cycle pulse: clear the accepted IRR bit
int_out  output  1  interrupt request to the CPU (registered)
vector_id  output  ID_W  index of the accepted channel
vector_valid  output  1  one-cycle pulse after inta_second

Behaviour:
- Reset, all synchronous: in_service=0, irr_clear=0, int_out=0, vector_id=0, vector_valid=0, lowest_prio=NUM_IRQ-1 (IR0 highest), state=IDLE.
- Priority order: the highest-priority channel is (lowest_prio+1) mod NUM_IRQ, descending with wrap-around. Both resolvers use this order.
- Definitions:
  - cand = highest-priority bit of irq_pending.
  - top_isr = highest-priority bit of in_service.
  - A request is eligible when cand exists and is strictly higher priority than top_isr, or in_service==0.
- int_out is registered, 1-cycle latency: int_out <= eligible while state==IDLE. It is held at 0 in WAIT_ACK2.
- FSM states: IDLE, WAIT_ACK2.
  - IDLE + inta_first with an eligible request: in_service[cand] set, irr_clear[cand] pulses for 1 cycle, vector_id <= cand, go to WAIT_ACK2.
  - IDLE + inta_first with no eligible request (spurious): vector_id <= NUM_IRQ-1, no ISR set, no irr_clear, go to WAIT_ACK2.
  - WAIT_ACK2 + inta_second: vector_valid pulses for 1 cycle, go to IDLE. If aeoi_mode and the accept was not spurious, clear in_service[vector_id] in the same edge. If rotate_on_eoi is also set, lowest_prio <= vector_id.
  - inta_first in WAIT_ACK2 is ignored. inta_second in IDLE is ignored (no vector_valid).
- EOI:
  - Specific: clears in_service[eoi_level]. If rotate_on_eoi, lowest_prio <= eoi_level. This applies even if the bit was already clear.
  - Non-specific: clears top_isr. If rotate_on_eoi, lowest_prio <= top_isr. With in_service==0 it is a full no-op (no rotation).
  - If specific and non-specific arrive together, specific wins and non-specific is dropped.
  - eoi_level >= NUM_IRQ: the EOI is ignored.
- Update rule per edge: in_service <= (in_service & ~clr) | set. clr is the OR of the EOI clear and the AEOI clear; set is the INTA accept. If set and clr hit the same bit, set wins.
- Pointer precedence: prio_set beats any rotation in the same cycle.
- vector_id holds its value until the next inta_first.
- Reset mid-handshake: return to IDLE; no vector_valid is emitted.

Decomposition:
- pic_pkg: typedef for the FSM state enum (IDLE, WAIT_ACK2) and a localparam for the reset pointer value (NUM_IRQ-1).
- Sub-module pic_priority_resolver: combinational rotating priority encoder with inputs req[NUM_IRQ] and lowest_prio[ID_W], and outputs found and idx[ID_W]. It is instantiated twice, once for irq_pending and once for in_service.

Test Plan:
- Reset, then irq_pending=8'h24 -> int_out=1 one cycle later. inta_first -> in_service=8'h04, irr_clear=8'h04 for 1 cycle. inta_second -> vector_valid pulse, vector_id=2.
- With in_service=8'h04, irq_pending=8'h10 -> int_out stays 0. irq_pending=8'h01 -> int_out=1. After the accept, in_service=8'h05. Non-specific EOI -> in_service=8'h04.
- aeoi_mode=1, rotate_on_eoi=1, accept IR3 -> in_service=0 right after inta_second, and lowest_prio=3. irq_pending=8'h11 -> IR4 wins (vector_id=4).
- inta_first with irq_pending=0 -> vector_id=7, in_service unchanged, irr_clear=0. inta_second -> vector_valid pulse.
- eoi_specific(level 5) and eoi_nonspecific in the same cycle with in_service=8'h21 -> in_service=8'h01. prio_set(level 6) while a rotation is pending -> lowest_prio=6.
- reset asserted in WAIT_ACK2, then inta_second -> no vector_valid. All outputs are at their reset values one cycle after reset.
